// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the arrival-order arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, GRANT)
//   HOLD_W       : width of the grant-hold counter (covers MAX_HOLD up to 255)
//   arb_id_bits  : bits needed to hold a requester index for n requesters
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int HOLD_W = 8;

  // Index width for n requesters; never below one bit so a two-line
  // arbiter still has a usable grant_id.
  function automatic int arb_id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo -- ordered queue of requester IDs.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_vec       : one bit per ID; all set bits are appended in ascending
//                    index order in a single cycle
//   push_extra     : append push_extra_id after the push_vec entries
//   push_extra_id  : ID appended by push_extra
//   pop            : drop the head entry (ignored when empty)
//   head           : ID at the head of the queue
//   count          : registered occupancy
//   empty          : count == 0
//   member         : bit i set while ID i is somewhere in the queue
//
// Stored as a shift register with entry 0 at the head.  The caller
// guarantees no ID is pushed while already present, so DEPTH entries can
// never overflow; the bound checks below only keep out-of-range writes away.
module arb_id_fifo
  import arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IW    = arb_id_bits(DEPTH),
  localparam int CW    = IW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] push_vec,
  input  logic             push_extra,
  input  logic [IW-1:0]    push_extra_id,
  input  logic             pop,
  output logic [IW-1:0]    head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic [DEPTH-1:0] member
);

  logic [IW-1:0] ent_reg  [DEPTH];
  logic [IW-1:0] ent_next [DEPTH];
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Pop first (shift toward the head), then append pushes at the running
  // tail so same-cycle pushes land in ascending order, extra push last.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_next[i] = ent_reg[i];
    end
    cnt_next = cnt_reg;

    if (pop && (cnt_reg != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_next[i] = ent_reg[i + 1];
      end
      ent_next[DEPTH-1] = '0;
      cnt_next = cnt_reg - CW'(1);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (push_vec[i] && (cnt_next < CW'(DEPTH))) begin
        ent_next[cnt_next[IW-1:0]] = IW'(i);
        cnt_next = cnt_next + CW'(1);
      end
    end

    if (push_extra && (cnt_next < CW'(DEPTH))) begin
      ent_next[cnt_next[IW-1:0]] = push_extra_id;
      cnt_next = cnt_next + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= '0;
      end
      cnt_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= ent_next[i];
      end
      cnt_reg <= cnt_next;
    end
  end

  // Membership of the valid entries, used upstream to refuse duplicates.
  always_comb begin
    member = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < cnt_reg) begin
        member[ent_reg[k]] = 1'b1;
      end
    end
  end

  assign head  = ent_reg[0];
  assign count = cnt_reg;
  assign empty = (cnt_reg == '0);

endmodule

// File: rtl/arrival_order_arbiter.sv
// arrival_order_arbiter -- grants a shared resource in order of request
// arrival (rising edge of a request line), not by index priority.
//   clk          : clock, all state on the rising edge
//   reset_n      : asynchronous active-low reset
//   rqst         : level request per requester
//   release_i    : current owner is done (only looked at during a grant)
//   grant        : registered one-hot grant (zero when idle)
//   grant_id     : index of the owner, 0 when idle
//   busy         : a grant is active
//   q_count      : IDs waiting in the queue (owner not included)
//   timeout      : one-cycle pulse when a grant is revoked at MAX_HOLD
//
// A grant ends on release_i, on the owner dropping its request, or when
// the hold counter reaches MAX_HOLD.  An owner still requesting when its
// grant ends goes back to the tail behind any same-cycle arrivals.  There
// is always at least one grant-free cycle between owners.
module arrival_order_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQUESTS = 4,
  parameter  int MAX_HOLD     = 16,
  localparam int IW           = arb_id_bits(NUM_REQUESTS),
  localparam int CW           = IW + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQUESTS-1:0] rqst,
  input  logic                    release_i,
  output logic [NUM_REQUESTS-1:0] grant,
  output logic [IW-1:0]           grant_id,
  output logic                    busy,
  output logic [CW-1:0]           q_count,
  output logic                    timeout
);

  localparam logic [NUM_REQUESTS-1:0] ONE = {{(NUM_REQUESTS-1){1'b0}}, 1'b1};

  arb_state_e              state_reg;
  logic [NUM_REQUESTS-1:0] rqst_d_reg;
  logic [NUM_REQUESTS-1:0] grant_reg;
  logic [IW-1:0]           id_reg;
  logic                    busy_reg;
  logic                    timeout_reg;
  logic [HOLD_W-1:0]       hold_reg;

  logic [NUM_REQUESTS-1:0] arrivals;
  logic [NUM_REQUESTS-1:0] member;
  logic [IW-1:0]           head;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    owner_rqst;
  logic                    hold_max;
  logic                    in_grant;
  logic                    rel_now;
  logic                    requeue;
  logic                    forced;
  logic                    pop;

  // Rising edges only.  An ID already waiting (withdrawn and re-raised
  // before it reached the head) or currently owning is not queued again,
  // which is what keeps the queue from ever holding a duplicate.
  assign arrivals   = rqst & ~rqst_d_reg & ~member & ~grant_reg;

  assign owner_rqst = rqst[id_reg];
  assign hold_max   = (hold_reg == HOLD_W'(MAX_HOLD));
  assign in_grant   = (state_reg == GRANT);
  assign rel_now    = in_grant && (release_i || !owner_rqst || hold_max);
  assign requeue    = rel_now && owner_rqst;
  assign forced     = in_grant && hold_max && !release_i && owner_rqst;

  // In IDLE the head leaves the queue every cycle: either it becomes the
  // owner or, if its line has dropped, it is discarded.
  assign pop        = (state_reg == IDLE) && !fifo_empty;

  arb_id_fifo #(
    .DEPTH(NUM_REQUESTS)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_vec     (arrivals),
    .push_extra   (requeue),
    .push_extra_id(id_reg),
    .pop          (pop),
    .head         (head),
    .count        (fifo_count),
    .empty        (fifo_empty),
    .member       (member)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      rqst_d_reg  <= '0;
      grant_reg   <= '0;
      id_reg      <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      hold_reg    <= '0;
    end else begin
      rqst_d_reg  <= rqst;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty && rqst[head]) begin
            grant_reg <= ONE << head;
            id_reg    <= head;
            busy_reg  <= 1'b1;
            hold_reg  <= HOLD_W'(1);
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (rel_now) begin
            grant_reg   <= '0;
            id_reg      <= '0;
            busy_reg    <= 1'b0;
            hold_reg    <= '0;
            timeout_reg <= forced;
            state_reg   <= IDLE;
          end else begin
            hold_reg <= hold_reg + HOLD_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_reg;
  assign grant_id = id_reg;
  assign busy     = busy_reg;
  assign q_count  = fifo_count;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_arrival_order_arbiter.sv
// tb_arrival_order_arbiter -- directed vectors for the arrival-order
// arbiter (4 requesters, MAX_HOLD = 4).  Each vector gives the inputs for
// one cycle and the registered outputs expected just after that cycle's
// clock edge; expectations are queued when the vector is driven and
// popped when the outputs are sampled.
module tb_arrival_order_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] rqst = 4'b0000;
  logic       release_i = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [2:0] q_count;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arrival_order_arbiter #(
    .NUM_REQUESTS(4),
    .MAX_HOLD    (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rqst     (rqst),
    .release_i(release_i),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .q_count  (q_count),
    .timeout  (timeout)
  );

  typedef struct {
    logic [3:0] rq;
    logic       rel;
    logic [3:0] g;
    logic [1:0] id;
    logic [2:0] qc;
    logic       to;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] rq, input logic rel,
                              input logic [3:0] g, input logic [1:0] id,
                              input logic [2:0] qc, input logic to);
    vec_t v;
    v.rq = rq; v.rel = rel; v.g = g; v.id = id; v.qc = qc; v.to = to;
    return v;
  endfunction

  task automatic compare(input string name, input vec_t e);
    logic eb;
    eb = (e.g != 4'b0000);
    checks++;
    if (grant !== e.g || grant_id !== e.id || busy !== eb ||
        q_count !== e.qc || timeout !== e.to) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b qc=%0d to=%b, want grant=%b id=%0d busy=%b qc=%0d to=%b",
               name, grant, grant_id, busy, q_count, timeout, e.g, e.id, eb, e.qc, e.to);
    end else begin
      $display("ok   %s: rqst=%b rel=%b -> grant=%b id=%0d qc=%0d to=%b",
               name, rqst, release_i, grant, grant_id, q_count, timeout);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    vec_t e;
    @(negedge clk);
    rqst      = v.rq;
    release_i = v.rel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(name, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Single arrival, release with line drop, release_i while idle.
    tbl.push_back(mk(4'b0100, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 4'b0100, 2, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 4'b0100, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
    // Staggered arrivals 3, 0, 1: served in arrival order with gaps.
    tbl.push_back(mk(4'b1000, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(4'b1001, 0, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(4'b1011, 0, 4'b1000, 3, 2, 0));
    tbl.push_back(mk(4'b0011, 1, 4'b0000, 0, 2, 0));
    tbl.push_back(mk(4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(4'b0010, 1, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(4'b0010, 0, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(4'b0010, 0, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
    // Simultaneous arrivals 1011: ascending order 0, 1, 3.
    tbl.push_back(mk(4'b1011, 0, 4'b0000, 0, 3, 0));
    tbl.push_back(mk(4'b1011, 0, 4'b0001, 0, 2, 0));
    tbl.push_back(mk(4'b1010, 1, 4'b0000, 0, 2, 0));
    tbl.push_back(mk(4'b1010, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(4'b1000, 1, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(4'b1000, 0, 4'b1000, 3, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));

    // Reset state while reset is held across a clock edge.
    @(posedge clk);
    #1;
    compare("reset", mk(4'b0000, 0, 4'b0000, 0, 0, 0));
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Forced release at MAX_HOLD=4: owner 1 re-queued behind pending 2.
    step("to_arr1",  mk(4'b0010, 0, 4'b0000, 0, 1, 0));
    step("to_g1",    mk(4'b0110, 0, 4'b0010, 1, 1, 0));
    step("to_h2",    mk(4'b0110, 0, 4'b0010, 1, 1, 0));
    step("to_h3",    mk(4'b0110, 0, 4'b0010, 1, 1, 0));
    step("to_h4",    mk(4'b0110, 0, 4'b0010, 1, 1, 0));
    step("to_fire",  mk(4'b0110, 0, 4'b0000, 0, 2, 1));
    step("to_g2",    mk(4'b0110, 0, 4'b0100, 2, 1, 0));
    step("to_rel2",  mk(4'b0010, 1, 4'b0000, 0, 1, 0));
    step("to_g1b",   mk(4'b0010, 0, 4'b0010, 1, 0, 0));
    step("to_wd1",   mk(4'b0000, 0, 4'b0000, 0, 0, 0));

    // Queue 2,3 behind owner 0; 2 withdraws and is discarded in IDLE.
    step("dq_arr0",  mk(4'b0001, 0, 4'b0000, 0, 1, 0));
    step("dq_g0",    mk(4'b0101, 0, 4'b0001, 0, 1, 0));
    step("dq_arr3",  mk(4'b1101, 0, 4'b0001, 0, 2, 0));
    step("dq_drop2", mk(4'b1001, 0, 4'b0001, 0, 2, 0));
    step("dq_rel0",  mk(4'b1000, 1, 4'b0000, 0, 2, 0));
    step("dq_disc2", mk(4'b1000, 0, 4'b0000, 0, 1, 0));
    step("dq_g3",    mk(4'b1000, 0, 4'b1000, 3, 0, 0));
    step("dq_wd3",   mk(4'b0000, 0, 4'b0000, 0, 0, 0));

    // Asynchronous reset mid-grant with two queued, then re-arrival.
    step("rs_arr",   mk(4'b0111, 0, 4'b0000, 0, 3, 0));
    step("rs_g0",    mk(4'b0111, 0, 4'b0001, 0, 2, 0));
    #2;
    reset_n = 1'b0;
    #1;
    compare("rs_async", mk(4'b0111, 0, 4'b0000, 0, 0, 0));
    @(posedge clk);
    #1;
    compare("rs_hold", mk(4'b0111, 0, 4'b0000, 0, 0, 0));
    reset_n = 1'b1;
    step("rs_rearr", mk(4'b0111, 0, 4'b0000, 0, 3, 0));
    step("rs_g0b",   mk(4'b0111, 0, 4'b0001, 0, 2, 0));
    step("rs_rel0",  mk(4'b0110, 1, 4'b0000, 0, 2, 0));
    step("rs_g1",    mk(4'b0110, 0, 4'b0010, 1, 1, 0));
    step("rs_rel1",  mk(4'b0100, 1, 4'b0000, 0, 1, 0));
    step("rs_g2",    mk(4'b0100, 0, 4'b0100, 2, 0, 0));
    step("rs_wd2",   mk(4'b0000, 0, 4'b0000, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arrival_order_arbiter.md
ARRIVAL_ORDER_ARBITER -- requirements
Module: arrival_order_arbiter

Interface
REQ-001 Parameter NUM_REQUESTS, default 4, number of request lines (2..16).
REQ-002 Parameter MAX_HOLD, default 16, maximum grant-hold cycles before forced release (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 rqst  input  NUM_REQUESTS  level request per requester; held high until served or withdrawn.
REQ-006 release_i  input  1  current grant owner finished; sampled only while a grant is active.
REQ-007 grant  output  NUM_REQUESTS  one-hot (or zero) registered grant.
REQ-008 grant_id  output  $clog2(NUM_REQUESTS)  index of granted requester; 0 when no grant.
REQ-009 busy  output  1  high while any grant bit is high.
REQ-010 q_count  output  $clog2(NUM_REQUESTS)+1  number of IDs currently queued (excludes owner).
REQ-011 timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

Function
REQ-012 Arrival = rising edge of rqst[i] (rqst[i] high, previous-cycle registered copy low); each arrival enqueues ID i at queue tail.
REQ-013 Simultaneous arrivals in one cycle enqueue in ascending index order; up to NUM_REQUESTS enqueues per cycle.
REQ-014 Queue depth NUM_REQUESTS; an ID is never present twice (queue plus owner); overflow is therefore impossible.
REQ-015 FSM states IDLE, GRANT; reset state IDLE.
REQ-016 IDLE, queue non-empty, rqst[head] high: pop head, next cycle grant[head]=1, grant_id=head, hold counter=1, go GRANT.
REQ-017 IDLE, queue non-empty, rqst[head] low (withdrawn): pop and discard head, no grant, stay IDLE; one discard per cycle.
REQ-018 IDLE, queue empty: grant stays 0; arrival in cycle N yields earliest grant in cycle N+2 (edge register + pop).
REQ-019 GRANT: hold counter increments each cycle; release when release_i=1, rqst[owner]=0, or counter reaches MAX_HOLD.
REQ-020 On release grant clears next cycle and FSM returns to IDLE; minimum one grant-free gap cycle between owners.
REQ-021 Release by counter reaching MAX_HOLD (with release_i=0 and rqst[owner]=1) pulses timeout in the same cycle grant clears.
REQ-022 If rqst[owner] still high on release (release_i or timeout), owner ID re-enqueues at tail in that cycle, after same-cycle new arrivals.
REQ-023 release_i while IDLE is ignored.
REQ-024 q_count reflects post-update queue occupancy, registered.

Reset
REQ-025 Asynchronous assertion: grant=0, grant_id=0, busy=0, q_count=0, timeout=0, FSM=IDLE, queue empty, hold counter=0, rqst edge register=0.
REQ-026 Reset mid-grant drops grant immediately; lines held high at deassertion count as arrivals on the first clock after reset.

Structure
REQ-027 Package arb_pkg holds state enum arb_state_e (IDLE, GRANT) and ID-width constant/function.
REQ-028 Sub-module arb_id_fifo: multi-push (ascending), single-pop ID queue with count output.
REQ-029 All outputs registered; no combinational input-to-output path.

Verification
REQ-030 rqst=4'b0100 at cycle 1 -> grant=4'b0100, grant_id=2 at cycle 3; release_i cycle 5 -> grant=0 cycle 6.
REQ-031 rqst[3] rises cycle 1, rqst[0] cycle 2, rqst[1] cycle 3, each releasing after 2 grant cycles -> grant order 3,0,1 (arrival, not index), one gap cycle between.
REQ-032 rqst=4'b1011 all rise same cycle -> grant order 0,1,3; q_count=2 after first grant.
REQ-033 MAX_HOLD=4, owner 1 never releases, rqst[1] held -> grant drops after 4 cycles, timeout pulses once, ID 1 re-queued behind pending ID 2.
REQ-034 Queue 2,3; rqst[2] drops before grant -> ID 2 discarded, grant goes to 3 one cycle later.
REQ-035 reset_n low during GRANT with q_count=2 -> all outputs 0 asynchronously; held lines re-arrive after deassertion in ascending index order.
